// File: rtl/bp_cfg_buffered_arb.sv
// bp_cfg_buffered_arb: per-channel command FIFOs, round-robin arbitration onto a
// single valid/yumi config target, tag FIFO for in-order response routing back
// to per-channel response FIFOs.
// Optional feature: define BP_CFG_BUFFERED_TIMEOUT_EN to enable the watchdog.
module bp_cfg_buffered_arb #(
    parameter int unsigned num_ch_p          = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned cmd_els_p         = 2,
    parameter int unsigned resp_els_p        = 2,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned timeout_p         = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_ch_p*msg_width_p-1:0]        mem_cmd_i,
    input  logic [num_ch_p-1:0]                    mem_cmd_v_i,
    output logic [num_ch_p-1:0]                    mem_cmd_ready_o,
    output logic [num_ch_p*msg_width_p-1:0]        mem_resp_o,
    output logic [num_ch_p-1:0]                    mem_resp_v_o,
    input  logic [num_ch_p-1:0]                    mem_resp_yumi_i,
    output logic [msg_width_p-1:0]                 tgt_cmd_o,
    output logic                                   tgt_cmd_v_o,
    input  logic                                   tgt_cmd_yumi_i,
    input  logic [msg_width_p-1:0]                 tgt_resp_i,
    input  logic                                   tgt_resp_v_i,
    output logic                                   tgt_resp_ready_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   err_o,
    output logic                                   timeout_o
);

    localparam int unsigned tag_w_lp       = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
    localparam int unsigned cnt_w_lp       = $clog2(max_outstanding_p + 1);
    localparam int unsigned tag_ptr_w_lp   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int unsigned cmd_ptr_w_lp   = $clog2(cmd_els_p);
    localparam int unsigned cmd_cnt_w_lp   = $clog2(cmd_els_p + 1);
    localparam int unsigned resp_ptr_w_lp  = $clog2(resp_els_p);
    localparam int unsigned resp_cnt_w_lp  = $clog2(resp_els_p + 1);

    typedef enum logic [0:0] {ST_IDLE, ST_LOCK} lock_state_e;

    lock_state_e               state_q, state_d;
    logic                      lock_held;
    logic [tag_w_lp-1:0]       lock_ch_q;
    logic [tag_w_lp-1:0]       rr_q;

    logic [msg_width_p-1:0]    cmd_data [num_ch_p];
    logic [num_ch_p-1:0]       cmd_full, cmd_empty;
    logic [num_ch_p-1:0]       resp_full, resp_empty;

    logic                      arb_found;
    logic [tag_w_lp-1:0]       arb_ch;
    logic                      gnt_v;
    logic [tag_w_lp-1:0]       gnt_ch;
    logic                      issue;

    logic [tag_w_lp-1:0]       tag_mem_q [max_outstanding_p];
    logic [tag_ptr_w_lp-1:0]   tag_wr_q, tag_rd_q;
    logic [cnt_w_lp-1:0]       tag_cnt_q;
    logic                      tag_empty;
    logic [tag_w_lp-1:0]       tag_head;
    logic                      resp_accept;
    logic                      err_q;

    // Round-robin search: first non-empty channel at or after the pointer
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_ch    = '0;
        for (int unsigned i = 0; i < num_ch_p; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= num_ch_p) idx = idx - num_ch_p;
            if (!arb_found && !cmd_empty[tag_w_lp'(idx)]) begin
                arb_found = 1'b1;
                arb_ch    = tag_w_lp'(idx);
            end
        end
    end

    // Grant: a held lock wins; otherwise a fresh grant needs tag space
    always_comb begin
        gnt_v  = arb_found && (tag_cnt_q < cnt_w_lp'(max_outstanding_p));
        gnt_ch = arb_ch;
        if (lock_held) begin
            gnt_v  = 1'b1;
            gnt_ch = lock_ch_q;
        end
    end

    assign issue       = gnt_v & tgt_cmd_yumi_i;
    assign tgt_cmd_v_o = gnt_v;
    assign tgt_cmd_o   = cmd_data[gnt_ch];

    // Lock FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Lock FSM next state: lock while the target stalls, release on yumi
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_v && !tgt_cmd_yumi_i) state_d = ST_LOCK;
            ST_LOCK: if (tgt_cmd_yumi_i)           state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Lock FSM outputs
    always_comb begin
        lock_held = 1'b0;
        if (state_q == ST_LOCK) lock_held = 1'b1;
    end

    // Locked channel id and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lock_ch_q <= '0;
            rr_q      <= '0;
        end else begin
            if (!lock_held && gnt_v) lock_ch_q <= gnt_ch;
            if (issue) begin
                if (32'(gnt_ch) == num_ch_p - 1) rr_q <= '0;
                else                             rr_q <= gnt_ch + tag_w_lp'(1);
            end
        end
    end

    // Per-channel command FIFOs
    for (genvar c = 0; c < num_ch_p; c++) begin : g_cmd
        logic [msg_width_p-1:0]  mem_q [cmd_els_p];
        logic [cmd_ptr_w_lp-1:0] wr_q, rd_q;
        logic [cmd_cnt_w_lp-1:0] cnt_q;
        logic                    push, pop;

        assign push               = mem_cmd_v_i[c] & ~cmd_full[c];
        assign pop                = issue & (gnt_ch == tag_w_lp'(c));
        assign cmd_full[c]        = (cnt_q == cmd_cnt_w_lp'(cmd_els_p));
        assign cmd_empty[c]       = (cnt_q == '0);
        assign cmd_data[c]        = mem_q[rd_q];
        assign mem_cmd_ready_o[c] = ~cmd_full[c];

        // Command storage
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_q] <= mem_cmd_i[c*msg_width_p +: msg_width_p];
        end

        // Command pointers and occupancy
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= (wr_q == cmd_ptr_w_lp'(cmd_els_p - 1)) ? '0 : wr_q + cmd_ptr_w_lp'(1);
                if (pop)  rd_q <= (rd_q == cmd_ptr_w_lp'(cmd_els_p - 1)) ? '0 : rd_q + cmd_ptr_w_lp'(1);
                cnt_q <= cnt_q + cmd_cnt_w_lp'(push) - cmd_cnt_w_lp'(pop);
            end
        end
    end

    // Tag FIFO bookkeeping; its occupancy is the outstanding count
    assign tag_empty        = (tag_cnt_q == '0);
    assign tag_head         = tag_mem_q[tag_rd_q];
    assign outstanding_o    = tag_cnt_q;
    assign tgt_resp_ready_o = ~tag_empty & ~resp_full[tag_head];
    assign resp_accept      = tgt_resp_v_i & tgt_resp_ready_o;

    // Tag storage
    always_ff @(posedge clk_i) begin
        if (issue) tag_mem_q[tag_wr_q] <= gnt_ch;
    end

    // Tag pointers and outstanding count
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (issue)
                tag_wr_q <= (tag_wr_q == tag_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : tag_wr_q + tag_ptr_w_lp'(1);
            if (resp_accept)
                tag_rd_q <= (tag_rd_q == tag_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : tag_rd_q + tag_ptr_w_lp'(1);
            tag_cnt_q <= tag_cnt_q + cnt_w_lp'(issue) - cnt_w_lp'(resp_accept);
        end
    end

    // Per-channel response FIFOs
    for (genvar c = 0; c < num_ch_p; c++) begin : g_resp
        logic [msg_width_p-1:0]   mem_q [resp_els_p];
        logic [resp_ptr_w_lp-1:0] wr_q, rd_q;
        logic [resp_cnt_w_lp-1:0] cnt_q;
        logic                     push, pop;

        assign push          = resp_accept & (tag_head == tag_w_lp'(c));
        assign pop           = mem_resp_yumi_i[c] & ~resp_empty[c];
        assign resp_full[c]  = (cnt_q == resp_cnt_w_lp'(resp_els_p));
        assign resp_empty[c] = (cnt_q == '0);
        assign mem_resp_v_o[c] = ~resp_empty[c];
        assign mem_resp_o[c*msg_width_p +: msg_width_p] = mem_q[rd_q];

        // Response storage
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_q] <= tgt_resp_i;
        end

        // Response pointers and occupancy
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= (wr_q == resp_ptr_w_lp'(resp_els_p - 1)) ? '0 : wr_q + resp_ptr_w_lp'(1);
                if (pop)  rd_q <= (rd_q == resp_ptr_w_lp'(resp_els_p - 1)) ? '0 : rd_q + resp_ptr_w_lp'(1);
                cnt_q <= cnt_q + resp_cnt_w_lp'(push) - resp_cnt_w_lp'(pop);
            end
        end
    end

    // Consuming an empty response FIFO is a requester protocol violation
    always_ff @(posedge clk_i) begin
        if (reset_n_i) assert ((mem_resp_yumi_i & resp_empty) == '0);
    end

    // Sticky error: a response showed up with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (!reset_n_i)                     err_q <= 1'b0;
        else if (tgt_resp_v_i && tag_empty) err_q <= 1'b1;
    end

    assign err_o = err_q;

`ifdef BP_CFG_BUFFERED_TIMEOUT_EN
    localparam int unsigned to_w_lp = $clog2(timeout_p + 1);

    logic [to_w_lp-1:0] wd_cnt_q;
    logic               timeout_q;

    // Watchdog: counts cycles since the last response while anything is outstanding
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (resp_accept || tag_empty)              wd_cnt_q <= '0;
            else if (wd_cnt_q != to_w_lp'(timeout_p))  wd_cnt_q <= wd_cnt_q + to_w_lp'(1);
            if (wd_cnt_q == to_w_lp'(timeout_p))       timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_p;
    assign unused_timeout_p = ^32'(timeout_p);
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cfg_buffered_arb.sv
// Directed bench for bp_cfg_buffered_arb: per-cycle vector table plus
// hand-written multi-cycle sequences (ordering, back-pressure, errors, watchdog).
module tb_bp_cfg_buffered_arb;

    localparam int unsigned NCH = 2;
    localparam int unsigned W   = 16;

    logic             clk;
    logic             reset_n;
    logic [NCH*W-1:0] mem_cmd;
    logic [NCH-1:0]   mem_cmd_v;
    logic [NCH-1:0]   mem_cmd_ready;
    logic [NCH*W-1:0] mem_resp;
    logic [NCH-1:0]   mem_resp_v;
    logic [NCH-1:0]   mem_resp_yumi;
    logic [W-1:0]     tgt_cmd;
    logic             tgt_cmd_v;
    logic             tgt_cmd_yumi;
    logic [W-1:0]     tgt_resp;
    logic             tgt_resp_v;
    logic             tgt_resp_ready;
    logic [2:0]       outstanding;
    logic             err;
    logic             timeout;

    bp_cfg_buffered_arb #(
        .num_ch_p(NCH), .msg_width_p(W), .cmd_els_p(2), .resp_els_p(2),
        .max_outstanding_p(4), .timeout_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .mem_cmd_i(mem_cmd), .mem_cmd_v_i(mem_cmd_v), .mem_cmd_ready_o(mem_cmd_ready),
        .mem_resp_o(mem_resp), .mem_resp_v_o(mem_resp_v), .mem_resp_yumi_i(mem_resp_yumi),
        .tgt_cmd_o(tgt_cmd), .tgt_cmd_v_o(tgt_cmd_v), .tgt_cmd_yumi_i(tgt_cmd_yumi),
        .tgt_resp_i(tgt_resp), .tgt_resp_v_i(tgt_resp_v), .tgt_resp_ready_o(tgt_resp_ready),
        .outstanding_o(outstanding), .err_o(err), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cv;
        logic [15:0] c0, c1;
        logic        ty;
        logic        rv;
        logic [15:0] rd;
        logic [1:0]  ry;
        logic        e_tcv;
        logic [15:0] e_tcmd;
        logic [2:0]  e_out;
        logic        e_trdy;
        logic [1:0]  e_rdy;
        logic [1:0]  e_rv;
        logic [15:0] e_r0, e_r1;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    int sent [2];
    int got  [2];
    int issued, acc, extra;
    logic [15:0] pend_d [$];
    int          pend_due [$];
    logic        exp_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_cmd       = '0;
        mem_cmd_v     = '0;
        mem_resp_yumi = '0;
        tgt_cmd_yumi  = 1'b0;
        tgt_resp      = '0;
        tgt_resp_v    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        idle();
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] tok(input int c, input int k);
        return ((c == 0) ? 16'h0A00 : 16'h0B00) | 16'(k);
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();

        // Vector table: A0 held 5 cycles, then B0, then responses routed per tag
        vecs[0]  = '{2'b11, 16'h0A00, 16'h0B00, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 16'h0,    3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[1]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[2]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[3]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[4]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[5]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[6]  = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0A00, 3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[7]  = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 16'h0,    2'b00, 1'b1, 16'h0B00, 3'd1, 1'b1, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[8]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b1, 16'h0E00, 2'b00, 1'b0, 16'h0,    3'd2, 1'b1, 2'b11, 2'b00, 16'h0,    16'h0};
        vecs[9]  = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b1, 16'h0E01, 2'b00, 1'b0, 16'h0,    3'd1, 1'b1, 2'b11, 2'b01, 16'h0E00, 16'h0};
        vecs[10] = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b01, 1'b0, 16'h0,    3'd0, 1'b0, 2'b11, 2'b11, 16'h0E00, 16'h0E01};
        vecs[11] = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b10, 1'b0, 16'h0,    3'd0, 1'b0, 2'b11, 2'b10, 16'h0,    16'h0E01};
        vecs[12] = '{2'b00, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 16'h0,    3'd0, 1'b0, 2'b11, 2'b00, 16'h0,    16'h0};

        // Reset values on the first cycle after a 3-cycle reset
        do_reset(3);
        chk("rst_tcv", 32'(tgt_cmd_v), 32'd0);
        chk("rst_out", 32'(outstanding), 32'd0);
        chk("rst_trdy", 32'(tgt_resp_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_respv", 32'(mem_resp_v), 32'd0);
        chk("rst_ready", 32'(mem_cmd_ready), 32'd3);

        // Table-driven per-cycle vectors
        for (int i = 0; i < NV; i++) begin
            mem_cmd_v     = vecs[i].cv;
            mem_cmd       = {vecs[i].c1, vecs[i].c0};
            tgt_cmd_yumi  = vecs[i].ty;
            tgt_resp_v    = vecs[i].rv;
            tgt_resp      = vecs[i].rd;
            mem_resp_yumi = vecs[i].ry;
            chk($sformatf("vec%0d_tcv", i), 32'(tgt_cmd_v), 32'(vecs[i].e_tcv));
            if (vecs[i].e_tcv) chk($sformatf("vec%0d_tcmd", i), 32'(tgt_cmd), 32'(vecs[i].e_tcmd));
            chk($sformatf("vec%0d_out", i), 32'(outstanding), 32'(vecs[i].e_out));
            chk($sformatf("vec%0d_trdy", i), 32'(tgt_resp_ready), 32'(vecs[i].e_trdy));
            chk($sformatf("vec%0d_rdy", i), 32'(mem_cmd_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_respv", i), 32'(mem_resp_v), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv[0]) chk($sformatf("vec%0d_r0", i), 32'(mem_resp[15:0]), 32'(vecs[i].e_r0));
            if (vecs[i].e_rv[1]) chk($sformatf("vec%0d_r1", i), 32'(mem_resp[31:16]), 32'(vecs[i].e_r1));
            step();
        end
        idle();

        // Two channels x 3 commands, always-yumi target, responses 2 cycles later
        do_reset(1);
        sent[0] = 0; sent[1] = 0; got[0] = 0; got[1] = 0; issued = 0;
        pend_d.delete(); pend_due.delete();
        for (int cyc = 0; cyc < 200 && !(got[0] == 3 && got[1] == 3); cyc++) begin
            for (int c = 0; c < 2; c++) begin
                mem_cmd_v[c]      = (sent[c] < 3);
                mem_cmd[c*W +: W] = tok(c, sent[c]);
                if (mem_cmd_v[c] && mem_cmd_ready[c]) sent[c]++;
            end
            tgt_cmd_yumi = 1'b1;
            if (tgt_cmd_v) begin
                chk("issue_order", 32'(tgt_cmd), 32'(tok(issued % 2, issued / 2)));
                issued++;
                pend_d.push_back(tgt_cmd ^ 16'hF000);
                pend_due.push_back(cyc + 2);
            end
            tgt_resp_v = 1'b0;
            if (pend_d.size() > 0 && pend_due[0] <= cyc) begin
                tgt_resp_v = 1'b1;
                tgt_resp   = pend_d[0];
                if (tgt_resp_ready) begin
                    void'(pend_d.pop_front());
                    void'(pend_due.pop_front());
                end
            end
            for (int c = 0; c < 2; c++) begin
                mem_resp_yumi[c] = mem_resp_v[c];
                if (mem_resp_v[c]) begin
                    chk("resp_route", 32'(mem_resp[c*W +: W]), 32'(tok(c, got[c]) ^ 16'hF000));
                    got[c]++;
                end
            end
            if (outstanding > 3'd4) chk("out_bound", 32'(outstanding), 32'd4);
            step();
        end
        idle();
        chk("seq_issued", 32'(issued), 32'd6);
        chk("seq_got0", 32'(got[0]), 32'd3);
        chk("seq_got1", 32'(got[1]), 32'd3);

        // No responses: 6 commands on ch0 stall at 4 outstanding
        do_reset(1);
        sent[0] = 0; issued = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            mem_cmd_v[0] = (sent[0] < 6);
            mem_cmd[W-1:0] = tok(0, sent[0]);
            if (mem_cmd_v[0] && mem_cmd_ready[0]) sent[0]++;
            tgt_cmd_yumi = 1'b1;
            if (tgt_cmd_v) issued++;
            step();
        end
        mem_cmd_v = '0;
        chk("full_sent", 32'(sent[0]), 32'd6);
        chk("full_issued", 32'(issued), 32'd4);
        chk("full_out", 32'(outstanding), 32'd4);
        chk("full_tcv", 32'(tgt_cmd_v), 32'd0);
        chk("full_ready0", 32'(mem_cmd_ready[0]), 32'd0);
        // One response: registered count still blocks this cycle
        tgt_resp_v = 1'b1;
        tgt_resp   = 16'h1234;
        chk("full_trdy", 32'(tgt_resp_ready), 32'd1);
        chk("full_tcv_same", 32'(tgt_cmd_v), 32'd0);
        step();
        tgt_resp_v = 1'b0;
        chk("one_resp_out", 32'(outstanding), 32'd3);
        extra = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (tgt_cmd_v) extra++;
            step();
        end
        chk("one_more_issue", 32'(extra), 32'd1);
        chk("refill_out", 32'(outstanding), 32'd4);
        // Reset mid-operation discards buffered command, response and tags
        do_reset(1);
        chk("midrst_out", 32'(outstanding), 32'd0);
        chk("midrst_tcv", 32'(tgt_cmd_v), 32'd0);
        chk("midrst_respv", 32'(mem_resp_v), 32'd0);
        chk("midrst_ready", 32'(mem_cmd_ready), 32'd3);

        // Response with nothing outstanding sets sticky err
        tgt_resp_v = 1'b1;
        tgt_resp   = 16'hDEAD;
        chk("err_trdy", 32'(tgt_resp_ready), 32'd0);
        chk("err_before", 32'(err), 32'd0);
        step();
        tgt_resp_v = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_out", 32'(outstanding), 32'd0);
        repeat (3) step();
        chk("err_sticky", 32'(err), 32'd1);

        // Head-of-line blocking: tags 1,1,1,0 with ch1 response FIFO left full
        do_reset(1);
        chk("hol_err_clr", 32'(err), 32'd0);
        sent[0] = 0; sent[1] = 0; issued = 0;
        for (int cyc = 0; cyc < 40 && issued < 4; cyc++) begin
            mem_cmd_v[1]     = (sent[1] < 3);
            mem_cmd[2*W-1:W] = tok(1, sent[1]);
            if (mem_cmd_v[1] && mem_cmd_ready[1]) sent[1]++;
            mem_cmd_v[0]     = (issued >= 3) && (sent[0] < 1);
            mem_cmd[W-1:0]   = tok(0, sent[0]);
            if (mem_cmd_v[0] && mem_cmd_ready[0]) sent[0]++;
            tgt_cmd_yumi = 1'b1;
            if (tgt_cmd_v) issued++;
            step();
        end
        idle();
        chk("hol_issued", 32'(issued), 32'd4);
        chk("hol_out", 32'(outstanding), 32'd4);
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tgt_resp_v = 1'b1;
            tgt_resp   = 16'(16'h5000 + cyc);
            if (tgt_resp_ready) acc++;
            step();
        end
        chk("hol_acc", 32'(acc), 32'd2);
        chk("hol_trdy", 32'(tgt_resp_ready), 32'd0);
        chk("hol_respv", 32'(mem_resp_v), 32'd2);
        chk("hol_out2", 32'(outstanding), 32'd2);
        mem_resp_yumi = 2'b10;
        step();
        mem_resp_yumi = 2'b00;
        chk("hol_release", 32'(tgt_resp_ready), 32'd1);
        idle();

        // Watchdog: one command, never answered
        do_reset(1);
        mem_cmd_v[0]   = 1'b1;
        mem_cmd[W-1:0] = 16'h0C00;
        step();
        mem_cmd_v    = '0;
        tgt_cmd_yumi = 1'b1;
        step();
        tgt_cmd_yumi = 1'b0;
        chk("wd_out", 32'(outstanding), 32'd1);
        repeat (3) step();
        chk("wd_early", 32'(timeout), 32'd0);
`ifdef BP_CFG_BUFFERED_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        repeat (20) step();
        chk("wd_late", 32'(timeout), 32'(exp_to));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
